// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: ALU op codes, opcodes,
// FSM state encodings and datapath mux select codes.
package ctrl_encode_def;

    typedef logic [4:0] alu_op_t;

    localparam alu_op_t ALUOP_ADD   = 5'd0;
    localparam alu_op_t ALUOP_SUB   = 5'd1;
    localparam alu_op_t ALUOP_SLL   = 5'd2;
    localparam alu_op_t ALUOP_SLT   = 5'd3;
    localparam alu_op_t ALUOP_SLTU  = 5'd4;
    localparam alu_op_t ALUOP_XOR   = 5'd5;
    localparam alu_op_t ALUOP_SRL   = 5'd6;
    localparam alu_op_t ALUOP_SRA   = 5'd7;
    localparam alu_op_t ALUOP_OR    = 5'd8;
    localparam alu_op_t ALUOP_AND   = 5'd9;
    localparam alu_op_t ALUOP_LUI   = 5'd10;
    localparam alu_op_t ALUOP_AUIPC = 5'd11;
    localparam alu_op_t ALUOP_JALR  = 5'd12;
    localparam alu_op_t ALUOP_BEQ   = 5'd13;
    localparam alu_op_t ALUOP_BNE   = 5'd14;
    localparam alu_op_t ALUOP_BLT   = 5'd15;
    localparam alu_op_t ALUOP_BGE   = 5'd16;
    localparam alu_op_t ALUOP_BLTU  = 5'd17;
    localparam alu_op_t ALUOP_BGEU  = 5'd18;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXECUTE = 4'd2,
        S_ALUWB   = 4'd3,
        S_MEMADR  = 4'd4,
        S_MEMRD   = 4'd5,
        S_MEMWB   = 4'd6,
        S_MEMWR   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd2;
    localparam logic [1:0] SRC_A_ZERO   = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    function automatic logic opcode_legal(input logic [6:0] opc);
        return (opc == OPC_OP)    || (opc == OPC_OP_IMM) || (opc == OPC_LUI)  ||
               (opc == OPC_AUIPC) || (opc == OPC_LOAD)   || (opc == OPC_STORE) ||
               (opc == OPC_BRANCH)|| (opc == OPC_JAL)    || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flag/handshake inputs and all
// control strobes and selects driven by the controller.
interface multicycle_ctrl_if #(parameter int ALUOP_W = 5);

    logic [31:0]        instr;
    logic               zero;
    logic               mem_ready;
    logic [ALUOP_W-1:0] ALUop;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               i_or_d;
    logic               reg_write;
    logic [1:0]         wb_sel;
    logic               illegal;
    logic [3:0]         state_o;

    modport master (
        input  instr, zero, mem_ready,
        output ALUop, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_read, mem_write, i_or_d, reg_write, wb_sel, illegal, state_o
    );

    modport slave (
        output instr, zero, mem_ready,
        input  ALUop, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
               mem_read, mem_write, i_or_d, reg_write, wb_sel, illegal, state_o
    );

endinterface

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// Combinational ALU operation decoder: (opcode, funct3, funct7[5]) -> ALU op,
// plus a flag saying whether funct3 names a real branch condition.
module alu_op_dec
    import ctrl_encode_def::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_t    alu_op,
    output logic       branch_ok
);

    assign branch_ok = (funct3 != 3'b010) && (funct3 != 3'b011);

    always_comb begin
        alu_op = ALUOP_ADD;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                case (funct3)
                    // Immediate forms reuse bit 30 as immediate data except for shift-right.
                    3'b000: alu_op = (funct7_5 && opcode == OPC_OP) ? ALUOP_SUB : ALUOP_ADD;
                    3'b001: alu_op = ALUOP_SLL;
                    3'b010: alu_op = ALUOP_SLT;
                    3'b011: alu_op = ALUOP_SLTU;
                    3'b100: alu_op = ALUOP_XOR;
                    3'b101: alu_op = funct7_5 ? ALUOP_SRA : ALUOP_SRL;
                    3'b110: alu_op = ALUOP_OR;
                    default: alu_op = ALUOP_AND;
                endcase
            end
            OPC_LUI:   alu_op = ALUOP_LUI;
            OPC_AUIPC: alu_op = ALUOP_AUIPC;
            OPC_JALR:  alu_op = ALUOP_JALR;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  alu_op = ALUOP_BEQ;
                    3'b001:  alu_op = ALUOP_BNE;
                    3'b100:  alu_op = ALUOP_BLT;
                    3'b101:  alu_op = ALUOP_BGE;
                    3'b110:  alu_op = ALUOP_BLTU;
                    3'b111:  alu_op = ALUOP_BGEU;
                    default: alu_op = ALUOP_ADD;
                endcase
            end
            default: alu_op = ALUOP_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM driving the datapath muxes, strobes and ALU op.
// Latency: branch/jump 3, ALU/store 4, load 5 cycles, +1 per memory wait cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready. CTRL_ILLEGAL_HALT_EN: illegal -> HALT.
module multicycle_ctrl
    import ctrl_encode_def::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         ALUOP_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master ctrl
);

    state_t     state, state_nxt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    alu_op_t    dec_op;
    logic       branch_ok;
    logic       instr_legal;

    alu_op_t    alu_op;
    logic [1:0] src_a, src_b, pc_src, wb_sel;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, illegal;

    logic       unused_instr_bits;

    assign opcode   = ctrl.instr[6:0];
    assign funct3   = ctrl.instr[14:12];
    assign funct7_5 = ctrl.instr[30];
    assign unused_instr_bits = ^{ctrl.instr[31], ctrl.instr[29:15], ctrl.instr[11:7]};

    alu_op_dec u_alu_op_dec (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_op    (dec_op),
        .branch_ok (branch_ok)
    );

    assign instr_legal = opcode_legal(opcode) && ((opcode != OPC_BRANCH) || branch_ok);

    always_ff @(posedge clk) begin
        if (rst) state <= state_t'(RESET_STATE);
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        alu_op    = ALUOP_ADD;
        src_a     = SRC_A_PC;
        src_b     = SRC_B_RS2;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_ALU;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_or_d    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALUOUT;
        illegal   = 1'b0;
        // Outputs are combinational, so reset must mask them to avoid a partial write.
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    src_b    = SRC_B_FOUR;
                    if (ctrl.mem_ready) begin
                        pc_write  = 1'b1;
                        ir_write  = 1'b1;
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
                    src_a = SRC_A_OLD_PC;
                    src_b = SRC_B_IMM;
                    if (!instr_legal) begin
                        illegal = 1'b1;
`ifdef CTRL_ILLEGAL_HALT_EN
                        state_nxt = S_HALT;
`else
                        state_nxt = S_FETCH;
`endif
                    end else begin
                        case (opcode)
                            OPC_LOAD, OPC_STORE: state_nxt = S_MEMADR;
                            OPC_BRANCH:          state_nxt = S_BRANCH;
                            OPC_JAL, OPC_JALR:   state_nxt = S_JUMP;
                            default:             state_nxt = S_EXECUTE;
                        endcase
                    end
                end
                S_EXECUTE: begin
                    alu_op    = dec_op;
                    state_nxt = S_ALUWB;
                    case (opcode)
                        OPC_OP:    src_a = SRC_A_RS1;
                        OPC_LUI:   begin src_a = SRC_A_ZERO;   src_b = SRC_B_IMM; end
                        OPC_AUIPC: begin src_a = SRC_A_OLD_PC; src_b = SRC_B_IMM; end
                        default:   begin src_a = SRC_A_RS1;    src_b = SRC_B_IMM; end
                    endcase
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_MEMADR: begin
                    src_a     = SRC_A_RS1;
                    src_b     = SRC_B_IMM;
                    state_nxt = (opcode == OPC_LOAD) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (ctrl.mem_ready) state_nxt = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_MDR;
                    state_nxt = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (ctrl.mem_ready) state_nxt = S_FETCH;
                end
                S_BRANCH: begin
                    src_a     = SRC_A_RS1;
                    alu_op    = dec_op;
                    pc_write  = ctrl.zero;
                    pc_src    = PC_SRC_ALUOUT;
                    state_nxt = S_FETCH;
                end
                S_JUMP: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_PC;
                    pc_write  = 1'b1;
                    state_nxt = S_FETCH;
                    if (opcode == OPC_JALR) begin
                        src_a  = SRC_A_RS1;
                        src_b  = SRC_B_IMM;
                        alu_op = dec_op;
                        pc_src = PC_SRC_JALR;
                    end else begin
                        pc_src = PC_SRC_ALUOUT;
                    end
                end
`ifdef CTRL_ILLEGAL_HALT_EN
                S_HALT: illegal = 1'b1;
`endif
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    assign ctrl.ALUop     = ALUOP_W'(alu_op);
    assign ctrl.alu_src_a = src_a;
    assign ctrl.alu_src_b = src_b;
    assign ctrl.pc_write  = pc_write;
    assign ctrl.pc_src    = pc_src;
    assign ctrl.ir_write  = ir_write;
    assign ctrl.mem_read  = mem_read;
    assign ctrl.mem_write = mem_write;
    assign ctrl.i_or_d    = i_or_d;
    assign ctrl.reg_write = reg_write;
    assign ctrl.wb_sel    = wb_sel;
    assign ctrl.illegal   = illegal;
    assign ctrl.state_o   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected output sequences built from
// the instruction-class rules, played cycle by cycle and compared on the falling edge.
module tb_multicycle_ctrl;
    import ctrl_encode_def::*;

    typedef struct packed {
        logic [4:0] alu;
        logic [1:0] sa, sb;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw, mr, mw, iod, rw;
        logic [1:0] wb;
        logic       ill;
        logic [3:0] st;
    } outv_t;

    typedef struct {
        logic        rst, rdy, z, st_chk;
        logic [31:0] ins;
        outv_t       e;
    } item_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    item_t q[$];
    outv_t exp_cur, act;
    logic  exp_vld = 1'b0;
    logic  st_chk  = 1'b0;
    int    checks = 0, errors = 0;
    int    cyc = 0, last_irw = 0, last_len = 0;

    multicycle_ctrl_if #(.ALUOP_W(5)) tb_if();
    multicycle_ctrl #(.RESET_STATE(4'd0), .ALUOP_W(5)) dut (.clk(clk), .rst(rst), .ctrl(tb_if));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legal(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (op == 7'b1100011) return (ins[14:12] != 3'd2) && (ins[14:12] != 3'd3);
        return op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                          7'b0100011, 7'b1101111, 7'b1100111};
    endfunction

    function automatic logic [4:0] exp_alu(input logic [31:0] ins);
        logic [4:0] base [8];
        logic [4:0] r;
        base = '{ALUOP_ADD, ALUOP_SLL, ALUOP_SLT, ALUOP_SLTU, ALUOP_XOR, ALUOP_SRL, ALUOP_OR, ALUOP_AND};
        if (ins[6:0] == 7'b0110111) return ALUOP_LUI;
        if (ins[6:0] == 7'b0010111) return ALUOP_AUIPC;
        r = base[ins[14:12]];
        if (ins[30] && ins[14:12] == 3'd5) r = ALUOP_SRA;
        if (ins[30] && ins[14:12] == 3'd0 && ins[6:0] == 7'b0110011) r = ALUOP_SUB;
        return r;
    endfunction

    function automatic logic [4:0] br_alu(input logic [2:0] f3);
        logic [4:0] t [8];
        t = '{ALUOP_BEQ, ALUOP_BNE, ALUOP_ADD, ALUOP_ADD, ALUOP_BLT, ALUOP_BGE, ALUOP_BLTU, ALUOP_BGEU};
        return t[f3];
    endfunction

    function automatic outv_t blank(input logic [3:0] st);
        outv_t e;
        e = '0;
        e.alu = ALUOP_ADD;
        e.st  = st;
        return e;
    endfunction

    task automatic push(input logic r, input logic rdy, input logic z, input logic [31:0] ins,
                        input outv_t e, input logic sc);
        item_t it;
        it.rst = r; it.rdy = rdy; it.z = z; it.ins = ins; it.e = e; it.st_chk = sc;
        q.push_back(it);
    endtask

    task automatic push_reset(input logic [31:0] ins);
        push(1'b1, rb(), rb(), ins, blank(S_FETCH), 1'b0);
        push(1'b1, rb(), rb(), ins, blank(S_FETCH), 1'b1);
    endtask

    task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic z, input bit cut);
        outv_t      e;
        logic [6:0] op;
        logic [3:0] mst;
        op = ins[6:0];
        e = blank(S_FETCH); e.mr = 1'b1; e.sb = 2'd1;
        for (int i = 0; i < fw; i++) push(1'b0, 1'b0, rb(), ins, e, 1'b1);
        e.pcw = 1'b1; e.irw = 1'b1;
        push(1'b0, 1'b1, rb(), ins, e, 1'b1);
        e = blank(S_DECODE); e.sa = 2'd2; e.sb = 2'd2; e.ill = !legal(ins);
        push(1'b0, rb(), rb(), ins, e, 1'b1);
        if (!legal(ins)) begin
`ifdef CTRL_ILLEGAL_HALT_EN
            e = blank(S_HALT); e.ill = 1'b1;
            for (int i = 0; i < 10; i++) push(1'b0, rb(), rb(), ins, e, 1'b1);
            push_reset(ins);
`endif
            return;
        end
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                e = blank(S_EXECUTE);
                e.alu = exp_alu(ins);
                e.sa  = (op == 7'b0010111) ? 2'd2 : (op == 7'b0110111) ? 2'd3 : 2'd1;
                e.sb  = (op == 7'b0110011) ? 2'd0 : 2'd2;
                push(1'b0, rb(), rb(), ins, e, 1'b1);
                e = blank(S_ALUWB); e.rw = 1'b1;
                push(1'b0, rb(), rb(), ins, e, 1'b1);
            end
            7'b0000011, 7'b0100011: begin
                e = blank(S_MEMADR); e.sa = 2'd1; e.sb = 2'd2;
                push(1'b0, rb(), rb(), ins, e, 1'b1);
                mst = (op == 7'b0000011) ? S_MEMRD : S_MEMWR;
                if (cut) begin
                    // Reset lands while the access is still pending: nothing may be strobed.
                    push(1'b1, 1'b0, rb(), ins, blank(mst), 1'b1);
                    return;
                end
                e = blank(mst); e.iod = 1'b1;
                if (op == 7'b0000011) e.mr = 1'b1; else e.mw = 1'b1;
                for (int i = 0; i < mw; i++) push(1'b0, 1'b0, rb(), ins, e, 1'b1);
                push(1'b0, 1'b1, rb(), ins, e, 1'b1);
                if (op == 7'b0000011) begin
                    e = blank(S_MEMWB); e.rw = 1'b1; e.wb = 2'd1;
                    push(1'b0, rb(), rb(), ins, e, 1'b1);
                end
            end
            7'b1100011: begin
                e = blank(S_BRANCH); e.sa = 2'd1; e.alu = br_alu(ins[14:12]);
                e.pcw = z; e.pcs = 2'd1;
                push(1'b0, rb(), z, ins, e, 1'b1);
            end
            default: begin
                e = blank(S_JUMP); e.rw = 1'b1; e.wb = 2'd2; e.pcw = 1'b1; e.pcs = 2'd1;
                if (op == 7'b1100111) begin
                    e.sa = 2'd1; e.sb = 2'd2; e.alu = ALUOP_JALR; e.pcs = 2'd2;
                end
                push(1'b0, rb(), rb(), ins, e, 1'b1);
            end
        endcase
    endtask

    task automatic play();
        item_t it;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(posedge clk);
            #1;
            rst             = it.rst;
            tb_if.instr     = it.ins;
            tb_if.mem_ready = it.rdy;
            tb_if.zero      = it.z;
            exp_cur         = it.e;
            st_chk          = it.st_chk;
            exp_vld         = 1'b1;
        end
    endtask

    task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic z, input bit cut);
        build(ins, fw, mw, z, cut);
        play();
    endtask

    task automatic check_val(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0:  r[6:0] = 7'b0110011;
            1:  r[6:0] = 7'b0010011;
            2:  r[6:0] = 7'b0110111;
            3:  r[6:0] = 7'b0010111;
            4:  r[6:0] = 7'b0000011;
            5:  r[6:0] = 7'b0100011;
            6:  r[6:0] = 7'b1100011;
            7:  r[6:0] = 7'b1101111;
            8:  r[6:0] = 7'b1100111;
            9:  r[6:0] = 7'b1100011;
            default: ;
        endcase
        return r;
    endfunction

    // ---------------- single compare process ----------------
    always @(negedge clk) begin
        outv_t mask;
        if (exp_vld) begin
            act.alu = tb_if.ALUop;     act.sa  = tb_if.alu_src_a; act.sb = tb_if.alu_src_b;
            act.pcw = tb_if.pc_write;  act.pcs = tb_if.pc_src;    act.irw = tb_if.ir_write;
            act.mr  = tb_if.mem_read;  act.mw  = tb_if.mem_write; act.iod = tb_if.i_or_d;
            act.rw  = tb_if.reg_write; act.wb  = tb_if.wb_sel;    act.ill = tb_if.illegal;
            act.st  = tb_if.state_o;
            mask = '1;
            if (!st_chk) mask.st = 4'h0;
            checks++;
            if (((act ^ exp_cur) & mask) !== '0) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t instr=%h rst=%b actual=%h required=%h",
                         $time, tb_if.instr, rst, act, exp_cur);
            end
            cyc++;
            if (tb_if.ir_write === 1'b1) begin
                last_len = cyc - last_irw;
                last_irw = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ins;
        tb_if.instr = 32'h0; tb_if.mem_ready = 1'b0; tb_if.zero = 1'b0;

        // Model pins against hand-decoded values.
        check_val("model_sub_alu", int'(exp_alu(32'h402081B3)), int'(ALUOP_SUB));
        check_val("model_srai_alu", int'(exp_alu(32'h4030D093)), int'(ALUOP_SRA));
        check_val("model_addi_neg_alu", int'(exp_alu(32'hFFF08093)), int'(ALUOP_ADD));
        check_val("model_zero_illegal", int'(legal(32'h00000000)), 0);
        check_val("model_bad_branch_f3", int'(legal(32'h0020A463)), 0);

        push_reset(32'h0);
        play();
        run(32'h002081B3, 0, 0, 1'b0, 1'b0);           // add x3,x1,x2
        run(32'h402081B3, 0, 0, 1'b0, 1'b0);           // sub
        check_val("add_cycles", last_len, 4);
        run(32'h4030D093, 0, 0, 1'b0, 1'b0);           // srai x1,x1,3
        check_val("sub_cycles", last_len, 4);
        build(32'h0080A283, 0, 2, 1'b0, 1'b0);         // lw x5,8(x1) with 2 wait cycles
        check_val("model_lw_len", q.size(), 7);
        play();
        check_val("srai_cycles", last_len, 4);
        run(32'h00208463, 0, 0, 1'b1, 1'b0);           // beq taken
        check_val("lw_wait2_cycles", last_len, 7);
        run(32'h00208463, 0, 0, 1'b0, 1'b0);           // beq not taken
        check_val("beq_taken_cycles", last_len, 3);
        run(32'h0020A423, 0, 0, 1'b0, 1'b0);           // sw x2,8(x1)
        check_val("beq_not_taken_cycles", last_len, 3);
        run(32'h008000EF, 0, 0, 1'b0, 1'b0);           // jal x1,8
        check_val("sw_cycles", last_len, 4);
        run(32'h00000000, 0, 0, 1'b0, 1'b0);           // illegal
        run(32'h0020A423, 1, 0, 1'b0, 1'b1);           // reset during MEMWR wait
        run(32'h002081B3, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            ins = rand_instr();
            run(ins, $urandom_range(0, 2), $urandom_range(0, 2), rb(), ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        exp_vld = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle RV32I control FSM; the driving end of the ALU interface.
- Consumes the latched instruction and the ALU `Zero` flag.
- Produces `ALUop`, operand selects, PC/IR/regfile/memory strobes and writeback select for the multicycle datapath.
- Sits between instruction register, memory handshake and datapath muxes.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).
- ALUOP_W, 5, width of the ALU operation code.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- instr  in  32  current instruction register contents.
- zero  in  1  ALU branch-taken flag (1 = take).
- mem_ready  in  1  memory completes the current access this cycle.
- ALUop  out  5  ALU operation select.
- alu_src_a  out  2  0=PC, 1=rs1, 2=old_pc, 3=zero.
- alu_src_b  out  2  0=rs2, 1=const 4, 2=imm.
- pc_write  out  1  load PC.
- pc_src  out  2  0=ALU result, 1=ALUOut reg, 2=ALU result & ~1.
- ir_write  out  1  load IR and old_pc.
- mem_read  out  1  memory read request (fetch or load).
- mem_write  out  1  memory write request.
- i_or_d  out  1  0=address from PC, 1=address from ALUOut.
- reg_write  out  1  regfile write enable.
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC (= old_pc+4).
- illegal  out  1  illegal instruction detected (sticky under halt feature).
- state_o  out  4  current state, for debug.

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-high `rst`.
- During `rst` all strobes are 0: pc_write, ir_write, mem_read, mem_write, reg_write. Also `ALUop`=ALUOP_ADD, selects=0, `illegal`=0.
- The state register returns to FETCH on the first edge with `rst` high, including mid-instruction. No partial write occurs.
- States: FETCH, DECODE, EXECUTE, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, HALT. Encodings live in the package.
- Outputs are combinational from state, instr, zero and mem_ready.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, ALU computes PC+4 (src_a=0, src_b=1, ADD).
  - Holds while mem_ready=0, with pc_write/ir_write=0.
  - When mem_ready=1: pc_write=1, pc_src=0, ir_write=1, then go to DECODE.
- DECODE:
  - ALU computes old_pc+imm (src_a=2, src_b=2, ADD); the result lands in ALUOut.
  - Dispatch on opcode:
    - OP, OP-IMM, LUI, AUIPC -> EXECUTE.
    - LOAD, STORE -> MEMADR.
    - BRANCH -> BRANCH.
    - JAL, JALR -> JUMP.
    - Other -> illegal path.
- EXECUTE:
  - ALUop from the decoder:
    - OP uses funct3 with funct7[5] selecting SUB/SRA.
    - OP-IMM uses funct3, with funct7[5] only for shift-right; SLLI/SRLI/SRAI take shamt from imm.
    - LUI uses LUI with src_b=imm.
    - AUIPC uses AUIPC with src_a=old_pc.
  - Next state: ALUWB.
- ALUWB: reg_write=1, wb_sel=0, then go to FETCH.
- MEMADR: rs1+imm (src_a=1, src_b=2, ADD); go to MEMRD for load, MEMWR for store.
- MEMRD: mem_read=1, i_or_d=1; hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, wb_sel=1, then go to FETCH.
- MEMWR: mem_write=1, i_or_d=1; hold until mem_ready, then go to FETCH.
- BRANCH:
  - src_a=1, src_b=0.
  - ALUop by funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - pc_write=zero, pc_src=1. Next state: FETCH.
  - funct3 010/011 is illegal.
- JUMP:
  - reg_write=1, wb_sel=2.
  - JAL: pc_write=1, pc_src=1.
  - JALR: src_a=1, src_b=2, ALUop=JALR, pc_write=1, pc_src=2.
  - Next state: FETCH.
- Cycle counts: branch/jump 3; ALU/LUI/AUIPC/store 4; load 5. Each FETCH/MEMRD/MEMWR wait cycle adds one.
- rd=x0 writes are still asserted; the regfile discards them.

Optional Feature:
- Macro: CTRL_ILLEGAL_HALT_EN.
- Defined:
  - An illegal opcode or illegal branch funct3 in DECODE enters HALT.
  - HALT asserts illegal=1 with all strobes 0, and stays until rst.
- Undefined:
  - An illegal instruction is a NOP: DECODE -> FETCH.
  - illegal pulses high for that DECODE cycle only.

Decomposition:
- Shared package ctrl_encode_def holds:
  - ALUOP_* codes.
  - Opcode constants.
  - State encodings.
  - alu_src_a/alu_src_b/pc_src/wb_sel select codes.
- Sub-module alu_op_dec is combinational: (opcode, funct3, funct7[5]) -> ALUop, branch_ok.

Test Plan:
- Reset then instr=0x002081B3 (add x3,x1,x2), mem_ready=1 -> states FETCH, DECODE, EXECUTE(ALUop=ADD), ALUWB(reg_write=1, wb_sel=0), FETCH; 4 cycles.
- instr=0x402081B3 (sub) -> EXECUTE ALUop=SUB. instr=0x4030D093 (srai x1,x1,3) -> ALUop=SRA, src_b=2.
- instr=0x0080A283 (lw x5,8(x1)), mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with mem_read=1, i_or_d=1; then MEMWB reg_write=1, wb_sel=1.
- instr=0x00208463 (beq): zero=1 -> BRANCH pc_write=1, pc_src=1; repeat with zero=0 -> pc_write=0; both 3 cycles.
- instr=0x00000000 -> illegal=1. With CTRL_ILLEGAL_HALT_EN: state_o=HALT, strobes 0 for 10 cycles. Without it: back to FETCH.
- rst asserted in MEMWR with mem_ready=0 -> mem_write=0 that cycle, state FETCH next edge, no reg_write/pc_write.
